// File: rtl/mips_defs.sv
// Shared MIPS decode constants: R-type funct codes, ALU control codes and
// the multiply/divide unit state encoding.
package mips_defs;

  // R-type funct codes
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_ADDU  = 6'd33;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SUBU  = 6'd35;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_XOR   = 6'd38;
  localparam logic [5:0] F_NOR   = 6'd39;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLTU  = 6'd43;

  // ALU control codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Multiply/divide state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_MUL  = ST_MUL,
    S_DIV  = ST_DIV,
    S_FIX  = ST_FIX,
    S_FIN  = ST_FIN
  } md_state_t;

  function automatic logic is_mul_op(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [5:0] f);
    return (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] f);
    return (f == F_MULT) || (f == F_DIV);
  endfunction

endpackage

// File: rtl/mips_muldiv_negate.sv
// Conditional two's-complement negation. Used both to take operand
// magnitudes and to apply the final sign fix to results.
module mips_muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO complete here in one edge
// MUL   | shift-add multiply, one multiplier bit per cycle (WIDTH cycles)
// DIV   | restoring divide, one quotient bit per cycle (WIDTH cycles)
// FIX   | sign correction, HI/LO written at the end of this cycle
// FIN   | done pulse; HI/LO valid; a new start is accepted here too
module mips_muldiv
  import mips_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int W2 = 2 * WIDTH;

  md_state_t r_state, w_next;

  logic [CW-1:0]    r_cnt;
  logic [W2-1:0]    r_acc;     // product, or {0, quotient} during divide
  logic [WIDTH-1:0] r_rem;     // divide partial remainder (always < divisor)
  logic [WIDTH-1:0] r_dvs;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] r_a_raw;   // raw rs, returned in HI on divide by zero
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_sa, r_sb, r_is_div, r_div0;

  logic             w_accept, w_go_mul, w_go_div, w_last;
  logic             w_sa_in, w_sb_in;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic [WIDTH:0]   w_msum;
  logic [W2-1:0]    w_mul_next;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [W2-1:0]    w_prod_fix;
  logic [WIDTH-1:0] w_quo_fix, w_rem_fix;

  // FIN behaves like IDLE for request acceptance so ops can run back-to-back
  assign w_accept = (r_state == S_IDLE) || (r_state == S_FIN);
  assign w_go_mul = w_accept && start && is_mul_op(funct);
  assign w_go_div = w_accept && start && is_div_op(funct);
  assign w_last   = (r_cnt == '0);

  assign w_sa_in = is_signed_op(funct) & a[WIDTH-1];
  assign w_sb_in = is_signed_op(funct) & b[WIDTH-1];

  // Most negative input negates to itself, which read unsigned is 2^(WIDTH-1)
  mips_muldiv_negate #(.WIDTH(WIDTH)) u_mag_a (
    .i_neg (w_sa_in),
    .i_val (a),
    .o_val (w_mag_a)
  );

  mips_muldiv_negate #(.WIDTH(WIDTH)) u_mag_b (
    .i_neg (w_sb_in),
    .i_val (b),
    .o_val (w_mag_b)
  );

  // Multiply step: add multiplicand into the upper half when the current
  // multiplier bit (LSB) is set, then shift the whole product right.
  assign w_msum     = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_dvs} : '0);
  assign w_mul_next = {w_msum, r_acc[WIDTH-1:1]};

  // Divide step: shift the next dividend bit into the remainder and
  // subtract the divisor only if it fits.
  assign w_shift    = {r_rem, r_acc[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_dvs});
  assign w_rem_next = w_ge ? WIDTH'(w_shift - {1'b0, r_dvs}) : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_acc[WIDTH-2:0], w_ge};

  mips_muldiv_negate #(.WIDTH(W2)) u_fix_prod (
    .i_neg (r_sa ^ r_sb),
    .i_val (r_acc),
    .o_val (w_prod_fix)
  );

  mips_muldiv_negate #(.WIDTH(WIDTH)) u_fix_quo (
    .i_neg (r_sa ^ r_sb),
    .i_val (r_acc[WIDTH-1:0]),
    .o_val (w_quo_fix)
  );

  // Remainder takes the sign of the dividend
  mips_muldiv_negate #(.WIDTH(WIDTH)) u_fix_rem (
    .i_neg (r_sa),
    .i_val (r_rem),
    .o_val (w_rem_fix)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and status outputs
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    div0   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go_mul)      w_next = S_MUL;
        else if (w_go_div) w_next = S_DIV;
      end
      S_MUL: begin
        busy = 1'b1;
        if (w_last) w_next = S_FIX;
      end
      S_DIV: begin
        busy = 1'b1;
        if (w_last) w_next = S_FIX;
      end
      S_FIX: begin
        busy   = 1'b1;
        w_next = S_FIN;
      end
      S_FIN: begin
        done = 1'b1;
        div0 = r_div0;
        if (w_go_mul)      w_next = S_MUL;
        else if (w_go_div) w_next = S_DIV;
        else               w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Iteration datapath, operand capture and HI/LO write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_a_raw  <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_is_div <= 1'b0;
      r_div0   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt - CW'(1);
        end
        S_DIV: begin
          r_acc <= {{WIDTH{1'b0}}, w_quo_next};
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          if (!r_is_div) begin
            r_hi <= w_prod_fix[W2-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end else if (r_div0) begin
            r_hi <= r_a_raw;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end
        end
        default: ;
      endcase

      if (w_accept && start) begin
        if (funct == F_MTHI) r_hi <= a;
        if (funct == F_MTLO) r_lo <= a;
        if (w_go_mul || w_go_div) begin
          r_cnt    <= CW'(WIDTH - 1);
          r_rem    <= '0;
          r_a_raw  <= a;
          r_sa     <= w_sa_in;
          r_sb     <= w_sb_in;
          r_is_div <= w_go_div;
          r_div0   <= w_go_div && (b == '0);
          r_acc    <= {{WIDTH{1'b0}}, (w_go_mul ? w_mag_b : w_mag_a)};
          r_dvs    <= w_go_mul ? w_mag_a : w_mag_b;
        end
      end
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_mips_muldiv.sv
// Bench for mips_muldiv: directed scenarios plus random mult/div on a
// 32-bit and an 8-bit instance, checked against an arithmetic model.
module tb_mips_muldiv;
  import mips_defs::*;

  logic        clk = 1'b0;
  logic        rst32, rst8;
  logic        start32, start8;
  logic [5:0]  funct32, funct8;
  logic [31:0] a32, b32, hi32, lo32;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy32, done32, div032, busy8, done8, div08;

  int checks = 0;
  int errors = 0;
  logic [63:0] m_hi [2];
  logic [63:0] m_lo [2];

  always #5 clk = ~clk;

  mips_muldiv #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst32), .start(start32), .funct(funct32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .div0(div032), .hi(hi32), .lo(lo32)
  );

  mips_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst8), .start(start8), .funct(funct8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div0(div08), .hi(hi8), .lo(lo8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int ix(input int w);
    return (w == 32) ? 1 : 0;
  endfunction

  function automatic logic [63:0] g_hi(input int w);
    return (w == 32) ? {32'b0, hi32} : {56'b0, hi8};
  endfunction
  function automatic logic [63:0] g_lo(input int w);
    return (w == 32) ? {32'b0, lo32} : {56'b0, lo8};
  endfunction
  function automatic logic g_busy(input int w);
    return (w == 32) ? busy32 : busy8;
  endfunction
  function automatic logic g_done(input int w);
    return (w == 32) ? done32 : done8;
  endfunction
  function automatic logic g_div0(input int w);
    return (w == 32) ? div032 : div08;
  endfunction

  task automatic drive(input int w, input logic s, input logic [5:0] f,
                       input logic [63:0] av, input logic [63:0] bv);
    if (w == 32) begin
      start32 = s; funct32 = f; a32 = av[31:0]; b32 = bv[31:0];
    end else begin
      start8 = s; funct8 = f; a8 = av[7:0]; b8 = bv[7:0];
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands
  function automatic void ref_op(input int w, input logic [5:0] f,
                                 input logic [63:0] av, input logic [63:0] bv,
                                 output logic [63:0] rhi, output logic [63:0] rlo,
                                 output logic rdz);
    logic [63:0] mk;
    logic [63:0] p;
    longint      sa, sb;
    bit          sgn;
    mk  = (64'd1 << w) - 64'd1;
    sgn = (f == F_MULT) || (f == F_DIV);
    sa  = (sgn && av[w-1]) ? longint'(av) - (longint'(1) << w) : longint'(av);
    sb  = (sgn && bv[w-1]) ? longint'(bv) - (longint'(1) << w) : longint'(bv);
    rdz = 1'b0;
    if ((f == F_MULT) || (f == F_MULTU)) begin
      p   = 64'(sa * sb);
      rhi = (p >> w) & mk;
      rlo = p & mk;
    end else if (bv == 64'd0) begin
      rhi = av;
      rlo = mk;
      rdz = 1'b1;
    end else begin
      rlo = 64'(sa / sb) & mk;
      rhi = 64'(sa % sb) & mk;
    end
  endfunction

  // Issue one request; for mult/div wait for done and check everything.
  // inject >= 0 raises a MULTU start in that cycle of the operation.
  task automatic op(input int w, input logic [5:0] f, input logic [63:0] av,
                    input logic [63:0] bv, input int inject);
    logic [63:0] ehi, elo;
    logic        edz;
    int          n, nbusy, i;
    i = ix(w);
    @(negedge clk);
    drive(w, 1'b1, f, av, bv);
    @(posedge clk); #1;
    drive(w, 1'b0, 6'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    if (!((f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU))) begin
      if (f == F_MTHI) m_hi[i] = av;
      if (f == F_MTLO) m_lo[i] = av;
      chk("mt_busy", g_busy(w), 1'b0);
      chk("mt_done", g_done(w), 1'b0);
      chk("mt_hi", g_hi(w), m_hi[i]);
      chk("mt_lo", g_lo(w), m_lo[i]);
      return;
    end
    ref_op(w, f, av, bv, ehi, elo, edz);
    n = 1;
    nbusy = 0;
    while (!g_done(w) && n < 80) begin
      if (g_busy(w)) nbusy++;
      if (n == inject)
        drive(w, 1'b1, F_MULTU, {$urandom, $urandom}, {$urandom, $urandom});
      else if (n == inject + 1)
        drive(w, 1'b0, F_MULTU, 64'd0, 64'd0);
      @(posedge clk); #1;
      n++;
    end
    chk("done", g_done(w), 1'b1);
    chk("latency", 64'(n), 64'(w + 2));
    chk("busy_cycles", 64'(nbusy), 64'(w + 1));
    chk("busy_fin", g_busy(w), 1'b0);
    chk("hi", g_hi(w), ehi);
    chk("lo", g_lo(w), elo);
    chk("div0", g_div0(w), edz);
    m_hi[i] = ehi;
    m_lo[i] = elo;
  endtask

  initial begin
    int          w, ndone;
    logic [5:0]  f;
    logic [63:0] av, bv, mk;

    rst32 = 1'b1; rst8 = 1'b1;
    drive(32, 1'b0, 6'd0, 64'd0, 64'd0);
    drive(8, 1'b0, 6'd0, 64'd0, 64'd0);
    m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? 32 : 8;
      chk("rst_busy", g_busy(w), 1'b0);
      chk("rst_done", g_done(w), 1'b0);
      chk("rst_div0", g_div0(w), 1'b0);
      chk("rst_hi", g_hi(w), 64'd0);
      chk("rst_lo", g_lo(w), 64'd0);
    end
    @(negedge clk);
    rst32 = 1'b0; rst8 = 1'b0;

    op(32, F_MULTU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, -1);
    chk("multu_max_hi", g_hi(32), 64'hFFFF_FFFE);
    chk("multu_max_lo", g_lo(32), 64'h0000_0001);

    op(32, F_MULT, 64'hFFFF_FFF9, 64'd3, -1);
    chk("mult_neg_hi", g_hi(32), 64'hFFFF_FFFF);
    chk("mult_neg_lo", g_lo(32), 64'hFFFF_FFEB);
    op(32, F_DIV, 64'hFFFF_FFF9, 64'd2, -1);
    chk("div_neg_lo", g_lo(32), 64'hFFFF_FFFD);
    chk("div_neg_hi", g_hi(32), 64'hFFFF_FFFF);

    op(32, F_DIVU, 64'h1234, 64'd0, -1);
    chk("div0_hi", g_hi(32), 64'h1234);
    chk("div0_lo", g_lo(32), 64'hFFFF_FFFF);
    chk("div0_flag", g_div0(32), 1'b1);
    op(32, F_DIV, 64'h8000_0000, 64'hFFFF_FFFF, -1);
    chk("minneg1_lo", g_lo(32), 64'h8000_0000);
    chk("minneg1_hi", g_hi(32), 64'd0);
    chk("minneg1_div0", g_div0(32), 1'b0);
    @(posedge clk); #1;
    chk("div0_idle", g_div0(32), 1'b0);

    op(32, F_MTHI, 64'hDEAD_BEEF, 64'd0, -1);
    chk("mthi_hi", g_hi(32), 64'hDEAD_BEEF);
    op(32, F_ADD, 64'h55, 64'h66, -1);

    op(32, F_MULTU, 64'h0001_2345, 64'h0000_6789, 5);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) ndone++;
    end
    chk("single_done", 64'(ndone), 64'd0);

    // Reset in cycle 10 of a DIVU
    @(negedge clk);
    drive(32, 1'b1, F_DIVU, 64'h0BAD_F00D, 64'h0000_0123);
    @(posedge clk); #1;
    drive(32, 1'b0, 6'd0, 64'd0, 64'd0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst32 = 1'b1;
    @(posedge clk); #1;
    rst32 = 1'b0;
    chk("abort_busy", busy32, 1'b0);
    chk("abort_hi", {32'b0, hi32}, 64'd0);
    chk("abort_lo", {32'b0, lo32}, 64'd0);
    m_hi[1] = '0; m_lo[1] = '0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    op(32, F_MTLO, 64'h5, 64'd0, -1);
    chk("mtlo_after_abort", g_lo(32), 64'd5);

    op(8, F_MULT, 64'h80, 64'h80, -1);
    chk("w8_min_sq_hi", g_hi(8), 64'h40);
    chk("w8_min_sq_lo", g_lo(8), 64'h00);

    for (int k = 0; k < 1000; k++) begin
      w  = (k < 300) ? 32 : 8;
      mk = (64'd1 << w) - 64'd1;
      f  = F_MULT + 6'($urandom_range(0, 3));
      av = {$urandom, $urandom} & mk;
      bv = {$urandom, $urandom} & mk;
      case ($urandom_range(0, 9))
        0: bv = 64'd0;
        1: av = 64'd1 << (w - 1);
        2: bv = mk;
        3: av = mk;
        default: ;
      endcase
      op(w, f, av, bv, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
